// File: rtl/jt51_kcenc.sv
// Purpose: frequency-to-keycode encoder. It finds the largest KC/KF pair whose phase base
//          (the octave-shifted phase increment) does not exceed an 18-bit target.
// Latency: start accepted on cen cycle N, done pulses on cen cycle N+14.
// Backpressure: none. A start is taken only while idle, and cen=0 freezes every register.
// Ports: rst/clk/cen  async active-high reset, clock, clock enable
//        start/target request and 18-bit unsigned target phase base (sampled on acceptance)
//        busy/done    busy from acceptance until done; done is a one-cen-cycle pulse
//        kc/kf/under  result registers; they hold until the next done

module jt51_kcenc (
   input  logic        rst,
   input  logic        clk,
   input  logic        cen,
   input  logic        start,
   input  logic [17:0] target,
   output logic        busy,
   output logic        done,
   output logic [6:0]  kc,
   output logic [5:0]  kf,
   output logic        under
);

   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

   state_t      state_q, state_d;
   logic [17:0] target_q, target_d;
   logic [12:0] acc_q, acc_d;
   logic [3:0]  bit_q, bit_d;
   logic [6:0]  kc_d;
   logic [5:0]  kf_d;
   logic        under_d;

   logic [12:0] trial;
   logic [9:0]  rom_addr;
   logic [11:0] rom_p, rom_p0;
   logic [17:0] trial_pb, pb0;
   logic [2:0]  t_oct;

   // note_code = note + note/3. This skips the unused codes 3, 7, 11 and 15.
   function automatic logic [3:0] note_code(input logic [3:0] n);
      if (n >= 4'd9)      return n + 4'd3;
      else if (n >= 4'd6) return n + 4'd2;
      else if (n >= 4'd3) return n + 4'd1;
      else                return n;
   endfunction

   assign trial = acc_q | (13'd1 << bit_q);
   assign t_oct = trial[12:10];
   // Notes 12..15 alias the top entry of their octave (note 11, kf 63).
   // This keeps pb nondecreasing across the whole 13-bit index space.
   assign rom_addr = (trial[9:6] >= 4'd12) ? 10'd767 : trial[9:0];

   jt51_phinc_rom u_rom  (.keycode(rom_addr), .phinc(rom_p));
   jt51_phinc_rom u_rom0 (.keycode(10'd0),    .phinc(rom_p0));

   // Octave 2 is the unshifted reference. Octaves 0 and 1 shift right, octaves 3..7 shift left.
   always_comb begin
      trial_pb = {6'd0, rom_p};
      if (t_oct < 3'd2) trial_pb = {6'd0, rom_p} >> (3'd2 - t_oct);
      else              trial_pb = {6'd0, rom_p} << (t_oct - 3'd2);
   end

   assign pb0 = {6'd0, rom_p0} >> 2;

   always_comb begin
      logic [12:0] acc_nxt;
      logic [3:0]  note_f;
      logic [5:0]  kf_f;
      state_d  = state_q;
      target_d = target_q;
      acc_d    = acc_q;
      bit_d    = bit_q;
      kc_d     = kc;
      kf_d     = kf;
      under_d  = under;
      acc_nxt  = acc_q;
      note_f   = 4'd0;
      kf_f     = 6'd0;
      case (state_q)
         IDLE: begin
            if (start) begin
               target_d = target;
               acc_d    = 13'd0;
               bit_d    = 4'd12;
               state_d  = SEARCH;
            end
         end
         SEARCH: begin
            if (trial_pb <= target_q) acc_nxt = trial;
            acc_d = acc_nxt;
            if (bit_q == 4'd0) begin
               state_d = DONE;
               // Results are registered as DONE is entered, so they are valid with the pulse.
               note_f = acc_nxt[9:6];
               kf_f   = acc_nxt[5:0];
               if (note_f >= 4'd12) begin
                  note_f = 4'd11;
                  kf_f   = 6'd63;
               end
               under_d = (target_q < pb0);
               if (under_d) begin
                  kc_d = 7'd0;
                  kf_d = 6'd0;
               end else begin
                  kc_d = {acc_nxt[12:10], note_code(note_f)};
                  kf_d = kf_f;
               end
            end else begin
               bit_d = bit_q - 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         target_q <= 18'd0;
         acc_q    <= 13'd0;
         bit_q    <= 4'd0;
         kc       <= 7'd0;
         kf       <= 6'd0;
         under    <= 1'b0;
      end else if (cen) begin
         state_q  <= state_d;
         target_q <= target_d;
         acc_q    <= acc_d;
         bit_q    <= bit_d;
         kc       <= kc_d;
         kf       <= kf_d;
         under    <= under_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

endmodule

// Purpose: phase-increment table indexed by {note[3:0], kf[5:0]}. Each semitone base is
//          linearly interpolated toward the next semitone over 64 key fractions.
// Latency: combinational.
// Backpressure: none.
// Ports: keycode  {note 0..11, kf}; notes 12..15 read as note 11
//        phinc    12-bit phase increment for octave 2
module jt51_phinc_rom (
   input  logic [9:0]  keycode,
   output logic [11:0] phinc
);

   function automatic logic [11:0] note_base(input logic [3:0] n);
      case (n)
         4'd0:    return 12'd1299;
         4'd1:    return 12'd1376;
         4'd2:    return 12'd1458;
         4'd3:    return 12'd1545;
         4'd4:    return 12'd1637;
         4'd5:    return 12'd1734;
         4'd6:    return 12'd1837;
         4'd7:    return 12'd1946;
         4'd8:    return 12'd2062;
         4'd9:    return 12'd2184;
         4'd10:   return 12'd2314;
         4'd11:   return 12'd2452;
         default: return 12'd2598;  // next octave's first note, used as the interpolation end
      endcase
   endfunction

   logic [3:0]  n_lo, n_hi;
   logic [11:0] base_lo, base_hi, diff;
   logic [17:0] step;

   assign n_lo    = (keycode[9:6] >= 4'd12) ? 4'd11 : keycode[9:6];
   assign n_hi    = n_lo + 4'd1;
   assign base_lo = note_base(n_lo);
   assign base_hi = note_base(n_hi);
   assign diff    = base_hi - base_lo;
   assign step    = 18'(diff) * 18'(keycode[5:0]);
   assign phinc   = base_lo + step[17:6];

endmodule

// File: tb/tb_jt51_kcenc.sv
module tb_jt51_kcenc;

   logic        rst, clk, cen, start;
   logic [17:0] target;
   logic        busy, done, under;
   logic [6:0]  kc;
   logic [5:0]  kf;

   int checks = 0;
   int errors = 0;
   int ncen_g = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   jt51_kcenc dut (
      .rst(rst), .clk(clk), .cen(cen), .start(start), .target(target),
      .busy(busy), .done(done), .kc(kc), .kf(kf), .under(under)
   );

   typedef struct {
      logic [17:0] t;
      logic [6:0]  kc;
      logic [5:0]  kf;
      logic        un;
   } vec_t;

   vec_t vt[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Reference phase base for a linear code c = oct*768 + note*64 + kf.
   function automatic int nbase(input int n);
      case (n)
         0: return 1299;  1: return 1376;  2: return 1458;  3: return 1545;
         4: return 1637;  5: return 1734;  6: return 1837;  7: return 1946;
         8: return 2062;  9: return 2184; 10: return 2314; 11: return 2452;
         default: return 2598;
      endcase
   endfunction

   function automatic int pbm(input int c);
      int oct, note, k, p;
      oct  = c / 768;
      note = (c % 768) / 64;
      k    = c % 64;
      p    = nbase(note) + ((nbase(note + 1) - nbase(note)) * k) / 64;
      if (oct == 0)      return p / 4;
      else if (oct == 1) return p / 2;
      else               return p << (oct - 2);
   endfunction

   task automatic tick();
      @(posedge clk);
      if (cen) ncen_g++;
      @(negedge clk);
   endtask

   // One complete run. lat is the number of cen edges from the accepting edge up to the
   // first cycle in which done is visible. A run that never finishes gives -1.
   task automatic do_run(input string name, input logic [17:0] t, input bit half,
                         input bit poke, output logic [6:0] rkc, output logic [5:0] rkf,
                         output logic run, output int lat);
      start  = 1'b1;
      target = t;
      cen    = 1'b1;
      ncen_g = 0;
      tick();
      start  = 1'b0;
      target = 18'h15555;
      chk({name, " busy_after_start"}, busy, 1);
      lat = -1;
      for (int i = 0; i < 200 && lat < 0; i++) begin
         cen = half ? ~cen : 1'b1;
         if (poke && ncen_g == 3) begin
            start  = 1'b1;
            target = 18'd5196;
         end else begin
            start = 1'b0;
         end
         tick();
         if (done) lat = ncen_g;
      end
      start = 1'b0;
      rkc = kc;
      rkf = kf;
      run = under;
      chk({name, " latency"}, lat, 14);
      // A stall holds the done pulse. The next enabled edge ends it and returns to idle.
      cen = 1'b0;
      tick();
      chk({name, " done_stretched"}, done, 1);
      cen = 1'b1;
      tick();
      chk({name, " done_cleared"}, {busy, done}, 0);
   endtask

   initial begin
      logic [6:0] rkc;
      logic [5:0] rkf;
      logic       run;
      int         lat, seen;

      vt[0]  = '{18'd8248,   7'h4A, 6'd0,  1'b0};
      vt[1]  = '{18'd8249,   7'h4A, 6'd0,  1'b0};
      vt[2]  = '{18'd8251,   7'h4A, 6'd0,  1'b0};
      vt[3]  = '{18'd8252,   7'h4A, 6'd1,  1'b0};
      vt[4]  = '{18'd5190,   7'h3E, 6'd63, 1'b0};
      vt[5]  = '{18'd5195,   7'h3E, 6'd63, 1'b0};
      vt[6]  = '{18'd5196,   7'h40, 6'd0,  1'b0};
      vt[7]  = '{18'd0,      7'h00, 6'd0,  1'b1};
      vt[8]  = '{18'd323,    7'h00, 6'd0,  1'b1};
      vt[9]  = '{18'd325,    7'h00, 6'd4,  1'b0};
      vt[10] = '{18'd83039,  7'h7E, 6'd62, 1'b0};
      vt[11] = '{18'h3FFFF,  7'h7E, 6'd63, 1'b0};

      rst = 1'b1; cen = 1'b0; start = 1'b0; target = 18'd0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {busy, done, kc, kf, under}, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         do_run($sformatf("vec%0d", i), vt[i].t, 1'b0, 1'b0, rkc, rkf, run, lat);
         chk($sformatf("vec%0d result", i), {rkc, rkf, run}, {vt[i].kc, vt[i].kf, vt[i].un});
      end

      // A second start with a new target during the search must be ignored.
      do_run("poke", 18'd8248, 1'b0, 1'b1, rkc, rkf, run, lat);
      chk("poke result", {rkc, rkf, run}, {7'h4A, 6'd0, 1'b0});

      // cen toggling every cycle: same result and the same count of enabled edges.
      do_run("half_cen", 18'd5190, 1'b1, 1'b0, rkc, rkf, run, lat);
      chk("half_cen result", {rkc, rkf, run}, {7'h3E, 6'd63, 1'b0});

      // Asynchronous reset during the sixth search cycle.
      start = 1'b1; target = 18'd8248; cen = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      #1;
      chk("midrst outputs", {busy, done, kc, kf, under}, 0);
      tick();
      rst = 1'b0;
      seen = 0;
      repeat (20) begin
         tick();
         if (done) seen++;
      end
      chk("midrst no_done", seen, 0);
      do_run("after_rst", 18'd8248, 1'b0, 1'b0, rkc, rkf, run, lat);
      chk("after_rst result", {rkc, rkf, run}, {7'h4A, 6'd0, 1'b0});

      // Sweep of every octave and note, with kf in steps of 4 plus kf 63.
      for (int oct = 0; oct < 8; oct++) begin
         for (int note = 0; note < 12; note++) begin
            for (int k = 0; k < 68; k += 4) begin
               int c, c2, e_oct, e_note, e_kf;
               logic [6:0] ekc;
               c  = oct * 768 + note * 64 + ((k > 63) ? 63 : k);
               c2 = c;
               while (c2 < 6143 && pbm(c2 + 1) == pbm(c)) c2++;
               e_oct  = c2 / 768;
               e_note = (c2 % 768) / 64;
               e_kf   = c2 % 64;
               ekc    = 7'((e_oct << 4) | (e_note + e_note / 3));
               do_run("sweep", 18'(pbm(c)), 1'b0, 1'b0, rkc, rkf, run, lat);
               chk($sformatf("sweep code %0d", c), {rkc, rkf, run}, {ekc, 6'(e_kf), 1'b0});
               chk("sweep note_code_gap", (rkc[1:0] == 2'b11), 0);
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
